tone_mixer_pdm: RTL and testbench



---
 rtl/tone_mixer_pdm.sv | 158 +++++++++++++++
 tb/tb_tone_mixer_pdm.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tone_mixer_pdm.sv
`timescale 1ns/1ps
// tone_mixer_pdm
// Shapes the four gated square-wave tone lines of the organ with a 4-bit
// attack/decay envelope each, mixes them into a 6-bit level and converts
// that level to a single-bit pulse-density stream for one speaker pin.
//
// Ports
//   oneMHzClock   in   1     system clock, all state moves on its rising edge
//   reset         in   1     synchronous, active-high reset (clears every register)
//   toneIn        in   [1:4] raw tone lines, asynchronous to oneMHzClock
//   pdmOut        out  1     registered pulse-density audio output
//   mixLevel      out  [5:0] registered sum of the shaped channels, 0..60
//   channelActive out  [1:4] registered per-channel activity flags
module tone_mixer_pdm #(
    parameter int ACT_BITS    = 11,
    parameter int ATTACK_BITS = 8,
    parameter int DECAY_BITS  = 11
) (
    input  logic       oneMHzClock,
    input  logic       reset,
    input  logic [1:4] toneIn,
    output logic       pdmOut,
    output logic [5:0] mixLevel,
    output logic [1:4] channelActive
);

    localparam logic [3:0]             LEVEL_MAX   = 4'd15;
    localparam logic [3:0]             LEVEL_MIN   = 4'd0;
    localparam logic [ACT_BITS-1:0]    ACT_ZERO    = {ACT_BITS{1'b0}};
    localparam logic [ACT_BITS-1:0]    ACT_ONE     = {{(ACT_BITS-1){1'b0}}, 1'b1};
    localparam logic [ACT_BITS-1:0]    ACT_RELOAD  = {ACT_BITS{1'b1}};
    localparam logic [ATTACK_BITS-1:0] ATTACK_ONE  = {{(ATTACK_BITS-1){1'b0}}, 1'b1};
    localparam logic [DECAY_BITS-1:0]  DECAY_ONE   = {{(DECAY_BITS-1){1'b0}}, 1'b1};

    // Attack while the channel is active, decay while it is idle, saturating at both ends.
    function automatic logic [3:0] envelope_step(
        input logic [3:0] level,
        input logic       active,
        input logic       attack_tick,
        input logic       decay_tick
    );
        logic [3:0] result;
        if (active && attack_tick && (level != LEVEL_MAX)) begin
            result = level + 4'd1;
        end else if (!active && decay_tick && (level != LEVEL_MIN)) begin
            result = level - 4'd1;
        end else begin
            result = level;
        end
        return result;
    endfunction

    logic [1:4]             tone_meta_r;
    logic [1:4]             tone_sync_r;
    logic [1:4]             tone_del_r;
    logic [1:4]             edge_s;
    logic [ACT_BITS-1:0]    act_cnt_r      [1:4];
    logic [ACT_BITS-1:0]    act_cnt_next_s [1:4];
    logic [1:4]             active_r;
    logic [ATTACK_BITS-1:0] attack_cnt_r;
    logic [DECAY_BITS-1:0]  decay_cnt_r;
    logic                   attack_tick_s;
    logic                   decay_tick_s;
    logic [3:0]             level_r        [1:4];
    logic [3:0]             level_next_s   [1:4];
    logic [5:0]             mix_next_s;
    logic [5:0]             mix_r;
    logic [5:0]             acc_r;
    logic [6:0]             acc_sum_s;
    logic                   pdm_r;

    // A tone transition shows up as a one-cycle difference between sync and delay stages.
    assign edge_s        = tone_sync_r ^ tone_del_r;
    assign attack_tick_s = &attack_cnt_r;
    assign decay_tick_s  = &decay_cnt_r;
    // Carry out of the 6-bit accumulator is the pulse-density bit.
    assign acc_sum_s     = {1'b0, acc_r} + {1'b0, mix_r};

    // Per-channel next state: activity reload/countdown, envelope step, gated mix sum.
    always_comb begin
        mix_next_s = 6'd0;
        for (int i = 1; i <= 4; i++) begin
            if (edge_s[i]) begin
                act_cnt_next_s[i] = ACT_RELOAD;
            end else if (act_cnt_r[i] != ACT_ZERO) begin
                act_cnt_next_s[i] = act_cnt_r[i] - ACT_ONE;
            end else begin
                act_cnt_next_s[i] = act_cnt_r[i];
            end
            level_next_s[i] = envelope_step(level_r[i], active_r[i], attack_tick_s, decay_tick_s);
            // Only the high half of the delayed square wave contributes its envelope.
            if (tone_del_r[i]) begin
                mix_next_s = mix_next_s + {2'b00, level_r[i]};
            end else begin
                mix_next_s = mix_next_s;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous tone lines plus the edge-detect delay stage.
    always_ff @(posedge oneMHzClock) begin
        if (reset) begin
            tone_meta_r <= 4'b0000;
            tone_sync_r <= 4'b0000;
            tone_del_r  <= 4'b0000;
        end else begin
            tone_meta_r <= toneIn;
            tone_sync_r <= tone_meta_r;
            tone_del_r  <= tone_sync_r;
        end
    end

    // Free-running attack and decay prescalers shared by all channels.
    always_ff @(posedge oneMHzClock) begin
        if (reset) begin
            attack_cnt_r <= {ATTACK_BITS{1'b0}};
            decay_cnt_r  <= {DECAY_BITS{1'b0}};
        end else begin
            attack_cnt_r <= attack_cnt_r + ATTACK_ONE;
            decay_cnt_r  <= decay_cnt_r + DECAY_ONE;
        end
    end

    // Activity counters, registered activity flags and envelope levels.
    always_ff @(posedge oneMHzClock) begin
        if (reset) begin
            active_r <= 4'b0000;
            for (int i = 1; i <= 4; i++) begin
                act_cnt_r[i] <= ACT_ZERO;
                level_r[i]   <= LEVEL_MIN;
            end
        end else begin
            for (int i = 1; i <= 4; i++) begin
                act_cnt_r[i] <= act_cnt_next_s[i];
                active_r[i]  <= (act_cnt_r[i] != ACT_ZERO);
                level_r[i]   <= level_next_s[i];
            end
        end
    end

    // Mixer register and first-order sigma-delta modulator.
    always_ff @(posedge oneMHzClock) begin
        if (reset) begin
            mix_r <= 6'd0;
            acc_r <= 6'd0;
            pdm_r <= 1'b0;
        end else begin
            mix_r <= mix_next_s;
            acc_r <= acc_sum_s[5:0];
            pdm_r <= acc_sum_s[6];
        end
    end

    assign pdmOut        = pdm_r;
    assign mixLevel      = mix_r;
    assign channelActive = active_r;

endmodule

// File: tb/tb_tone_mixer_pdm.sv
`timescale 1ns/1ps
// Bench for tone_mixer_pdm: a behavioural cycle model predicts every output
// sample and queues it when the stimulus for that edge is applied; a phase
// table plus hand sequences cover latency, timeout, saturation and reset.
module tb_tone_mixer_pdm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:4] tone_in;
    logic       pdm_out;
    logic [5:0] mix_level;
    logic [1:4] channel_active;

    int check_cnt = 0;
    int error_cnt = 0;
    int cyc_cnt   = 0;

    logic [10:0] sb_q [$];

    // Reference model state (state after the most recent rising edge).
    logic [1:4] m_sync1, m_sync2, m_del, m_act;
    int         m_cnt [1:4];
    int         m_lvl [1:4];
    int         m_mix, m_acc, m_cyc;

    typedef struct {
        logic [1:4] start_val;
        logic [1:4] toggle_mask;
        int         half_period;
        int         toggle_cycles;
        logic [1:4] hold_val;
        int         hold_cycles;
        int         exp_mix;
        logic [1:4] exp_active;
        int         exp_ones;
    } phase_t;

    phase_t phases [4];

    tone_mixer_pdm dut (
        .oneMHzClock   (clk),
        .reset         (reset),
        .toneIn        (tone_in),
        .pdmOut        (pdm_out),
        .mixLevel      (mix_level),
        .channelActive (channel_active)
    );

    always #500 clk = ~clk;

    // Advance the model by one rising edge using the inputs about to be sampled.
    task automatic model_step();
        logic [1:4] n_act;
        int         n_mix;
        int         sum;
        logic       n_pdm;
        logic       a_tick, d_tick;
        if (reset) begin
            m_sync1 = 4'b0000; m_sync2 = 4'b0000; m_del = 4'b0000; m_act = 4'b0000;
            for (int i = 1; i <= 4; i++) begin m_cnt[i] = 0; m_lvl[i] = 0; end
            m_mix = 0; m_acc = 0; m_cyc = 0;
            sb_q.push_back(11'd0);
        end else begin
            a_tick = ((m_cyc % 256) == 255);
            d_tick = ((m_cyc % 2048) == 2047);
            n_mix  = 0;
            for (int i = 1; i <= 4; i++) begin
                n_act[i] = (m_cnt[i] != 0);
                if (m_del[i]) n_mix = n_mix + m_lvl[i];
                if (m_sync2[i] != m_del[i]) m_cnt[i] = 2047;
                else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                if (m_act[i] && a_tick && m_lvl[i] < 15) m_lvl[i] = m_lvl[i] + 1;
                else if (!m_act[i] && d_tick && m_lvl[i] > 0) m_lvl[i] = m_lvl[i] - 1;
            end
            sum     = m_acc + m_mix;
            n_pdm   = (sum >= 64);
            m_acc   = sum % 64;
            m_mix   = n_mix;
            m_act   = n_act;
            m_del   = m_sync2;
            m_sync2 = m_sync1;
            m_sync1 = tone_in;
            m_cyc   = m_cyc + 1;
            sb_q.push_back({n_pdm, 6'(n_mix), n_act});
        end
    endtask

    // One clock: queue the prediction, let the edge happen, compare on the falling edge.
    task automatic cycle();
        logic [10:0] exp_v;
        logic [10:0] got_v;
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc_cnt++;
        got_v = {pdm_out, mix_level, channel_active};
        check_cnt++;
        if (sb_q.size() == 0) begin
            error_cnt++;
            $display("FAIL scoreboard cycle %0d: no expected entry queued", cyc_cnt);
        end else begin
            exp_v = sb_q.pop_front();
            if (got_v !== exp_v) begin
                error_cnt++;
                $display("FAIL sample cycle %0d: got pdm=%b mix=%0d active=%b, expected pdm=%b mix=%0d active=%b",
                         cyc_cnt, got_v[10], got_v[9:4], got_v[3:0], exp_v[10], exp_v[9:4], exp_v[3:0]);
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        check_cnt++;
        if (got != exp) begin
            error_cnt++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc_cnt, got, exp);
        end
    endtask

    initial begin
        #(200_000_000);
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones;
        int n;
        int found;

        phases[0] = '{4'b0000, 4'b0000, 1,   0,    4'b0000, 3000, 0,  4'b0000, 0};
        phases[1] = '{4'b0000, 4'b1000, 956, 5736, 4'b0000, 100,  0,  4'b1000, 0};
        phases[2] = '{4'b0000, 4'b1111, 500, 5000, 4'b1111, 300,  60, 4'b1111, 60};
        phases[3] = '{4'b0010, 4'b0000, 1,   0,    4'b0010, 300,  15, 4'b1111, 15};

        // Reset held three cycles while the tone lines toggle.
        reset   = 1'b1;
        tone_in = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            cycle();
            tone_in = ~tone_in;
        end
        reset   = 1'b0;
        tone_in = 4'b0000;
        cycle();
        chk("reset pdmOut", int'(pdm_out), 0);
        chk("reset mixLevel", int'(mix_level), 0);
        chk("reset channelActive", int'(channel_active), 0);

        for (int p = 0; p < 4; p++) begin
            tone_in = phases[p].start_val;
            for (int c = 0; c < phases[p].toggle_cycles; c++) begin
                if ((c % phases[p].half_period) == 0) tone_in = tone_in ^ phases[p].toggle_mask;
                cycle();
            end
            tone_in = phases[p].hold_val;
            for (int c = 0; c < phases[p].hold_cycles; c++) cycle();
            chk($sformatf("phase %0d mixLevel", p), int'(mix_level), phases[p].exp_mix);
            chk($sformatf("phase %0d channelActive", p), int'(channel_active), int'(phases[p].exp_active));
            ones = 0;
            for (int c = 0; c < 64; c++) begin
                cycle();
                ones += int'(pdm_out);
            end
            chk($sformatf("phase %0d pdm ones per 64", p), ones, phases[p].exp_ones);

            if (p == 1) begin
                // Channel 1 at level 15: latency, activity timeout and full decay.
                tone_in = 4'b1000;
                cycle(); cycle(); cycle();
                chk("ch1 mix before latency", int'(mix_level), 0);
                cycle();
                chk("ch1 mix after 4 cycles", int'(mix_level), 15);
                n = 4;
                while (channel_active[1] && n < 3000) begin
                    cycle();
                    n++;
                end
                chk("ch1 active fall delay", n, 2051);
                cycle();
                chk("ch1 level held at timeout", int'(mix_level), 15);
                repeat (32768) cycle();
                chk("ch1 decayed to 0", int'(mix_level), 0);
                chk("ch1 inactive after decay", int'(channel_active), 0);
                repeat (2048) cycle();
                chk("ch1 no wrap below 0", int'(mix_level), 0);
            end
        end

        // Mix latency with channel 3 sounding: channel 1 joins four cycles later.
        tone_in = 4'b1010;
        cycle(); cycle(); cycle();
        chk("mix latency before", int'(mix_level), 15);
        cycle();
        chk("mix latency after", int'(mix_level), 30);

        // Reset in the middle of a channel-2 attack.
        reset   = 1'b1;
        tone_in = 4'b0000;
        cycle();
        reset = 1'b0;
        found = 0;
        for (int c = 0; c < 6000 && found == 0; c++) begin
            if ((c % 100) == 0) tone_in = tone_in ^ 4'b0100;
            cycle();
            if (mix_level == 6'd7) found = 1;
        end
        chk("ch2 attack reached 7", found, 1);
        tone_in = 4'b0100;
        reset   = 1'b1;
        cycle();
        chk("mid reset mixLevel", int'(mix_level), 0);
        chk("mid reset pdmOut", int'(pdm_out), 0);
        chk("mid reset channelActive", int'(channel_active), 0);
        reset = 1'b0;
        repeat (200) cycle();
        chk("attack restart level 0", int'(mix_level), 0);
        repeat (400) cycle();
        chk("attack restart level 2", int'(mix_level), 2);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
